commit_monitor: RTL and testbench
=================================

# commit_monitor

Retirement monitor that sits directly downstream of the pipelined core's debug port, in parallel with the bench scoreboard. It consumes the per-retirement debug signals (valid, PC, control-transfer, misprediction) and keeps saturating performance counters. It detects program end as a self-loop (`j .`) retiring repeatedly, and flags a stall watchdog timeout. Its `o_done` gives the bench one registered end-of-test condition, replacing blind timeouts.

## Interface
- `CNT_W`, 32: width of every counter.
- `LOOP_THRESH`, 4: consecutive valid retirements at the same PC that declare halt (≥2).
- `STALL_LIMIT`, 1024: consecutive RUN cycles without a retirement that declare timeout (≥1).

- `i_clk` in 1: clock, rising-edge.
- `i_reset` in 1: reset, asynchronous, active-high.
- `i_clear` in 1: synchronous clear to post-reset state; highest synchronous priority.
- `i_insn_vld` in 1: one instruction retires this cycle.
- `i_pc_debug` in 32: PC of the retiring instruction; qualified by `i_insn_vld`.
- `i_ctrl` in 1: retiring instruction is a branch or jump; qualified by `i_insn_vld`.
- `i_mispred` in 1: retiring control instruction was mispredicted; qualified by `i_insn_vld`.
- `o_cycle_cnt` out CNT_W: cycles spent in RUN.
- `o_insn_cnt` out CNT_W: retired instructions.
- `o_ctrl_cnt` out CNT_W: retired control instructions.
- `o_mispred_cnt` out CNT_W: retired mispredicted control instructions.
- `o_halt` out 1: self-loop halt detected (sticky).
- `o_halt_pc` out 32: PC of the self-loop.
- `o_timeout` out 1: stall watchdog fired (sticky).
- `o_done` out 1: `o_halt | o_timeout`.
- `o_err` out 1: protocol error, `i_mispred` with `i_insn_vld` and no `i_ctrl` (sticky).
- `o_err_pc` out 32: PC of the first protocol error.

## Operation
- States: IDLE (reset), RUN, HALTED, TIMEOUT. HALTED and TIMEOUT are terminal; only reset or `i_clear` leaves them.
- IDLE → RUN on the first `i_insn_vld`. That retirement is counted and `o_cycle_cnt` counts that cycle.
- RUN, every cycle:
  - `o_cycle_cnt` increments.
  - On `i_insn_vld`:
    - `o_insn_cnt` increments.
    - `o_ctrl_cnt` increments if `i_ctrl`.
    - `o_mispred_cnt` increments if `i_ctrl & i_mispred`.
    - The stall counter is zeroed.
  - Without `i_insn_vld`, the stall counter increments.
- Repeat tracking, on each valid retirement:
  - If `i_pc_debug` equals the last valid PC, the repeat count increments; otherwise it loads 1.
  - The last valid PC always updates.
  - Cycles with no valid retirement between two equal PCs do not break the run.
- RUN → HALTED on the retirement that brings the repeat count to LOOP_THRESH. That retirement is counted. `o_halt_pc` captures its PC.
- RUN → TIMEOUT when the stall counter reaches STALL_LIMIT.
- If the halt and timeout conditions coincide, halt wins. They cannot coincide, because a valid retirement zeroes the stall counter.
- In HALTED and TIMEOUT, all counters freeze and inputs are ignored, except for error capture (below).
- IDLE: counters do not advance except on the transitioning retirement. The watchdog is inactive, so a core held in reset never times out.
- Error capture, in any state:
  - Triggered by `i_insn_vld & i_mispred & ~i_ctrl`.
  - Sets `o_err`; `o_err_pc` captures only the first occurrence.
  - That retirement is not counted in `o_mispred_cnt`.
  - `i_mispred` without `i_insn_vld` is ignored.
- Arithmetic:
  - All counters saturate at 2^CNT_W−1; there is no wrap.
  - The repeat counter saturates at LOOP_THRESH.
  - The stall counter is sized clog2(STALL_LIMIT+1).
- `i_clear` returns every register to its reset value next edge, regardless of state. A retirement in the clear cycle is discarded.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs; `o_done` is decoded from registered state bits.
- Counter latency: a retirement at edge N is visible in the counters after edge N.
- Halt latency: `o_halt`, `o_halt_pc` and `o_done` assert after the edge sampling the LOOP_THRESH-th repeat.
- Timeout latency: `o_timeout` asserts after the edge where the stall counter reaches STALL_LIMIT. That is STALL_LIMIT idle RUN cycles after the last retirement.
- Reset (asynchronous assert; deassert synchronised by the bench):
  - State is IDLE.
  - All counters, `o_halt`, `o_timeout`, `o_done` and `o_err` are 0.
  - `o_halt_pc` and `o_err_pc` are 0.
  - The last valid PC is 0 and the repeat count is 0.
- Reset asserted mid-RUN aborts immediately; no partial state survives.

## Test plan
- Straight-line run: 10 retirements at PCs 0x0,0x4,…,0x24, one per cycle, then 0x28 four times → `o_insn_cnt`=14, `o_halt`=1, `o_halt_pc`=0x28, `o_cycle_cnt`=14.
- Branch stats: 8 retirements with `i_ctrl`=1, of which 3 have `i_mispred`=1 → `o_ctrl_cnt`=8, `o_mispred_cnt`=3, `o_err`=0.
- Watchdog (STALL_LIMIT=16): one retirement, then `i_insn_vld`=0 → `o_timeout`=1 exactly 16 cycles later; a retirement afterwards leaves counters unchanged. Repeat while still in IDLE → no timeout.
- Gapped self-loop: PC 0x40 retired 4 times with 2 idle cycles between each → halt at 0x40. Sequence 0x40,0x40,0x44,0x40,0x40 → no halt.
- Protocol error: `i_mispred`=1, `i_ctrl`=0, `i_insn_vld`=1 at PC 0x80, then the same at 0x90 → `o_err`=1, `o_err_pc`=0x80, `o_mispred_cnt` unchanged.
- Clear and saturation:
  - `i_clear` in HALTED → IDLE and all zeros next cycle.
  - With CNT_W=4, 20 retirements at distinct PCs → `o_insn_cnt`=15.
  - Async reset mid-RUN → outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/commit_monitor.sv
// rtl/commit_monitor.sv - retirement monitor: saturating perf counters, self-loop halt, stall watchdog
module commit_monitor #(
    parameter int CNT_W       = 32,
    parameter int LOOP_THRESH = 4,
    parameter int STALL_LIMIT = 1024
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_insn_vld,
    input  logic [31:0]      i_pc_debug,
    input  logic             i_ctrl,
    input  logic             i_mispred,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_insn_cnt,
    output logic [CNT_W-1:0] o_ctrl_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt,
    output logic             o_halt,
    output logic [31:0]      o_halt_pc,
    output logic             o_timeout,
    output logic             o_done,
    output logic             o_err,
    output logic [31:0]      o_err_pc
);

    localparam int REP_W   = $clog2(LOOP_THRESH + 1);
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [REP_W-1:0]   REP_ONE   = REP_W'(1);
    localparam logic [REP_W-1:0]   REP_MAX   = REP_W'(LOOP_THRESH);
    localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED,
        S_TIMEOUT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [CNT_W-1:0]   insn_q, insn_d;
    logic [CNT_W-1:0]   ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   mispred_q, mispred_d;
    logic [31:0]        halt_pc_q, halt_pc_d;
    logic               err_q, err_d;
    logic [31:0]        err_pc_q, err_pc_d;
    logic [31:0]        last_pc_q, last_pc_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               count_en;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + CNT_ONE : v;
    endfunction

    always_comb begin
        state_d   = state_q;
        cycle_d   = cycle_q;
        insn_d    = insn_q;
        ctrl_d    = ctrl_q;
        mispred_d = mispred_q;
        halt_pc_d = halt_pc_q;
        err_d     = err_q;
        err_pc_d  = err_pc_q;
        last_pc_d = last_pc_q;
        rep_d     = rep_q;
        stall_d   = stall_q;
        count_en  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_insn_vld) begin
                    state_d  = S_RUN;
                    count_en = 1'b1;
                end
            end
            S_RUN:   count_en = 1'b1;
            default: count_en = 1'b0;
        endcase

        if (count_en) begin
            cycle_d   = sat_inc(cycle_q, 1'b1);
            insn_d    = sat_inc(insn_q, i_insn_vld);
            ctrl_d    = sat_inc(ctrl_q, i_insn_vld & i_ctrl);
            mispred_d = sat_inc(mispred_q, i_insn_vld & i_ctrl & i_mispred);

            if (i_insn_vld) begin
                last_pc_d = i_pc_debug;
                stall_d   = '0;
                if (i_pc_debug == last_pc_q)
                    rep_d = (rep_q == REP_MAX) ? rep_q : rep_q + REP_ONE;
                else
                    rep_d = REP_ONE;
            end else if (state_q == S_RUN && stall_q != STALL_MAX) begin
                stall_d = stall_q + STALL_ONE;
            end

            // Halt is checked first; a retirement clears the stall count anyway.
            if (state_q == S_RUN) begin
                if (i_insn_vld && rep_d == REP_MAX) begin
                    state_d   = S_HALTED;
                    halt_pc_d = i_pc_debug;
                end else if (!i_insn_vld && stall_d == STALL_MAX) begin
                    state_d = S_TIMEOUT;
                end
            end
        end

        if (i_insn_vld && i_mispred && !i_ctrl) begin
            err_d = 1'b1;
            if (!err_q)
                err_pc_d = i_pc_debug;
        end

        if (i_clear) begin
            state_d   = S_IDLE;
            cycle_d   = '0;
            insn_d    = '0;
            ctrl_d    = '0;
            mispred_d = '0;
            halt_pc_d = '0;
            err_d     = 1'b0;
            err_pc_d  = '0;
            last_pc_d = '0;
            rep_d     = '0;
            stall_d   = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            cycle_q   <= '0;
            insn_q    <= '0;
            ctrl_q    <= '0;
            mispred_q <= '0;
            halt_pc_q <= '0;
            err_q     <= 1'b0;
            err_pc_q  <= '0;
            last_pc_q <= '0;
            rep_q     <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            insn_q    <= insn_d;
            ctrl_q    <= ctrl_d;
            mispred_q <= mispred_d;
            halt_pc_q <= halt_pc_d;
            err_q     <= err_d;
            err_pc_q  <= err_pc_d;
            last_pc_q <= last_pc_d;
            rep_q     <= rep_d;
            stall_q   <= stall_d;
        end
    end

    assign o_cycle_cnt   = cycle_q;
    assign o_insn_cnt    = insn_q;
    assign o_ctrl_cnt    = ctrl_q;
    assign o_mispred_cnt = mispred_q;
    assign o_halt        = (state_q == S_HALTED);
    assign o_halt_pc     = halt_pc_q;
    assign o_timeout     = (state_q == S_TIMEOUT);
    assign o_done        = (state_q == S_HALTED) || (state_q == S_TIMEOUT);
    assign o_err         = err_q;
    assign o_err_pc      = err_pc_q;

endmodule

// File: tb/tb_commit_monitor.sv
// tb/tb_commit_monitor.sv - scoreboard bench for commit_monitor
module tb_commit_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        vld;
    logic [31:0] pc;
    logic        ctl;
    logic        mis;

    logic [31:0] cyc, insn, ctrl_cnt, mis_cnt, hpc, epc;
    logic        halt, tmo, done, err;

    logic [3:0]  s_cyc, s_insn, s_ctrl, s_mis;
    logic [31:0] s_hpc, s_epc;
    logic        s_halt, s_tmo, s_done, s_err;

    always #5 clk = ~clk;

    commit_monitor #(.CNT_W(32), .LOOP_THRESH(4), .STALL_LIMIT(16)) dut (
        .i_clk(clk), .i_reset(rst), .i_clear(clr), .i_insn_vld(vld),
        .i_pc_debug(pc), .i_ctrl(ctl), .i_mispred(mis),
        .o_cycle_cnt(cyc), .o_insn_cnt(insn), .o_ctrl_cnt(ctrl_cnt),
        .o_mispred_cnt(mis_cnt), .o_halt(halt), .o_halt_pc(hpc),
        .o_timeout(tmo), .o_done(done), .o_err(err), .o_err_pc(epc)
    );

    commit_monitor #(.CNT_W(4), .LOOP_THRESH(4), .STALL_LIMIT(16)) dut_sat (
        .i_clk(clk), .i_reset(rst), .i_clear(clr), .i_insn_vld(vld),
        .i_pc_debug(pc), .i_ctrl(ctl), .i_mispred(mis),
        .o_cycle_cnt(s_cyc), .o_insn_cnt(s_insn), .o_ctrl_cnt(s_ctrl),
        .o_mispred_cnt(s_mis), .o_halt(s_halt), .o_halt_pc(s_hpc),
        .o_timeout(s_tmo), .o_done(s_done), .o_err(s_err), .o_err_pc(s_epc)
    );

    typedef enum int {
        G_CYC, G_INSN, G_CTRL, G_MIS, G_HALT, G_HPC, G_TMO, G_DONE, G_ERR, G_EPC, G_SINSN
    } sig_t;

    typedef struct {
        string       name;
        sig_t        sig;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic logic [31:0] get_sig(input sig_t s);
        case (s)
            G_CYC:   return cyc;
            G_INSN:  return insn;
            G_CTRL:  return ctrl_cnt;
            G_MIS:   return mis_cnt;
            G_HALT:  return {31'd0, halt};
            G_HPC:   return hpc;
            G_TMO:   return {31'd0, tmo};
            G_DONE:  return {31'd0, done};
            G_ERR:   return {31'd0, err};
            G_EPC:   return epc;
            G_SINSN: return {28'd0, s_insn};
            default: return 32'hdead_beef;
        endcase
    endfunction

    // Monitor: drains every expectation queued since the last falling edge.
    exp_t        m_e;
    logic [31:0] m_act;
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            m_e   = exp_q.pop_front();
            m_act = get_sig(m_e.sig);
            n_chk++;
            if (m_act !== m_e.val) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", m_e.name, m_act, m_e.val);
            end
        end
    end

    task automatic expect_sig(input string name, input sig_t s, input logic [31:0] v);
        exp_q.push_back('{name, s, v});
    endtask

    task automatic step(input logic v, input logic [31:0] p, input logic c, input logic m);
        vld = v; pc = p; ctl = c; mis = m;
        @(posedge clk);
        #1;
        vld = 1'b0; ctl = 1'b0; mis = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic do_clear();
        clr = 1'b1; vld = 1'b1; pc = 32'h55;
        @(posedge clk);
        #1;
        clr = 1'b0; vld = 1'b0;
    endtask

    initial begin
        logic [7:0] mis_pat;
        rst = 1'b1; clr = 1'b0; vld = 1'b0; pc = '0; ctl = 1'b0; mis = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        expect_sig("rst_cyc",  G_CYC,  0);
        expect_sig("rst_insn", G_INSN, 0);
        expect_sig("rst_halt", G_HALT, 0);
        expect_sig("rst_done", G_DONE, 0);
        expect_sig("rst_err",  G_ERR,  0);
        expect_sig("rst_hpc",  G_HPC,  0);

        // Straight-line run ending in a 4x self-loop at 0x28
        for (int i = 0; i < 10; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h28, 1'b0, 1'b0);
        expect_sig("line_nohalt_yet", G_HALT, 0);
        step(1'b1, 32'h28, 1'b0, 1'b0);
        expect_sig("line_insn",  G_INSN,  14);
        expect_sig("line_cyc",   G_CYC,   14);
        expect_sig("line_halt",  G_HALT,  1);
        expect_sig("line_hpc",   G_HPC,   32'h28);
        expect_sig("line_done",  G_DONE,  1);
        expect_sig("line_sinsn", G_SINSN, 14);
        step(1'b1, 32'h100, 1'b1, 1'b0);
        idle(2);
        expect_sig("halt_frozen_insn", G_INSN, 14);
        expect_sig("halt_frozen_cyc",  G_CYC,  14);
        expect_sig("halt_frozen_ctrl", G_CTRL, 0);

        do_clear();
        expect_sig("clr_cyc",  G_CYC,  0);
        expect_sig("clr_insn", G_INSN, 0);
        expect_sig("clr_halt", G_HALT, 0);
        expect_sig("clr_hpc",  G_HPC,  0);
        expect_sig("clr_done", G_DONE, 0);

        // Branch statistics
        mis_pat = 8'b0010_1001;
        for (int i = 0; i < 8; i++) step(1'b1, 32'h100 + 32'(i * 4), 1'b1, mis_pat[i]);
        expect_sig("br_ctrl", G_CTRL, 8);
        expect_sig("br_mis",  G_MIS,  3);
        expect_sig("br_insn", G_INSN, 8);
        expect_sig("br_cyc",  G_CYC,  8);
        expect_sig("br_err",  G_ERR,  0);
        do_clear();

        // Watchdog: inactive in IDLE, fires 16 idle RUN cycles after the last retirement
        idle(20);
        expect_sig("idle_no_tmo", G_TMO, 0);
        expect_sig("idle_cyc",    G_CYC, 0);
        step(1'b1, 32'h200, 1'b0, 1'b0);
        idle(15);
        expect_sig("wd_15_tmo", G_TMO, 0);
        expect_sig("wd_15_cyc", G_CYC, 16);
        idle(1);
        expect_sig("wd_16_tmo",  G_TMO,  1);
        expect_sig("wd_16_done", G_DONE, 1);
        expect_sig("wd_16_cyc",  G_CYC,  17);
        step(1'b1, 32'h204, 1'b0, 1'b0);
        expect_sig("wd_after_insn", G_INSN, 1);
        expect_sig("wd_after_cyc",  G_CYC,  17);
        expect_sig("wd_after_halt", G_HALT, 0);
        do_clear();

        // Gapped self-loop
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h40, 1'b0, 1'b0);
            idle(2);
        end
        expect_sig("gap_nohalt_yet", G_HALT, 0);
        step(1'b1, 32'h40, 1'b0, 1'b0);
        expect_sig("gap_halt", G_HALT, 1);
        expect_sig("gap_hpc",  G_HPC,  32'h40);
        expect_sig("gap_insn", G_INSN, 4);
        expect_sig("gap_cyc",  G_CYC,  10);
        do_clear();

        // Broken repeat run
        step(1'b1, 32'h40, 1'b0, 1'b0);
        step(1'b1, 32'h40, 1'b0, 1'b0);
        step(1'b1, 32'h44, 1'b0, 1'b0);
        step(1'b1, 32'h40, 1'b0, 1'b0);
        step(1'b1, 32'h40, 1'b0, 1'b0);
        expect_sig("brk_halt", G_HALT, 0);
        expect_sig("brk_insn", G_INSN, 5);
        do_clear();

        // Protocol error
        step(1'b0, 32'h70, 1'b0, 1'b1);
        expect_sig("err_novld", G_ERR, 0);
        step(1'b1, 32'h80, 1'b0, 1'b1);
        step(1'b1, 32'h90, 1'b0, 1'b1);
        expect_sig("err_flag", G_ERR,  1);
        expect_sig("err_pc",   G_EPC,  32'h80);
        expect_sig("err_mis",  G_MIS,  0);
        expect_sig("err_insn", G_INSN, 2);
        do_clear();
        expect_sig("err_clr", G_ERR, 0);

        // Saturation on the narrow instance, then async reset mid-RUN
        for (int i = 0; i < 20; i++) step(1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b0);
        expect_sig("sat_sinsn", G_SINSN, 15);
        expect_sig("sat_insn",  G_INSN,  20);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        expect_sig("arst_cyc",   G_CYC,   0);
        expect_sig("arst_insn",  G_INSN,  0);
        expect_sig("arst_sinsn", G_SINSN, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b1, 32'h400, 1'b0, 1'b0);
        expect_sig("post_rst_insn", G_INSN, 1);
        expect_sig("post_rst_cyc",  G_CYC,  1);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
